// File: rtl/nv_nvdla_sdp_mrdma_pkg.sv
// Shared definitions for the SDP MRDMA read-request arbiter.
//   arb_state_e          : sequencer states (IDLE -> RUN -> DONE -> IDLE)
//   SDP_MRDMA_RD_REQ_PW  : read-request payload width
//   REQ_MUL/REQ_ALU/REQ_BN : requester index assignment on the shared channel
package nv_nvdla_sdp_mrdma_pkg;

  localparam int SDP_MRDMA_RD_REQ_PW = 79;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic [1:0] REQ_MUL = 2'd0;
  localparam logic [1:0] REQ_ALU = 2'd1;
  localparam logic [1:0] REQ_BN  = 2'd2;

endpackage

// File: rtl/nv_nvdla_sdp_mrdma_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   : request vector, one bit per requester
//   ptr_i   : index searched first (must be < NREQ)
//   en_i    : when low, nothing is granted
//   grant_o : one-hot grant (or zero)
//   idx_o   : index of the granted requester
//   any_o   : a grant was issued
module nv_nvdla_sdp_mrdma_rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [1:0]      ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [1:0]      idx_o,
  output logic            any_o
);

  // cand[k] is the requester examined at priority position k: (ptr + k) mod NREQ.
  // ptr < NREQ, so one conditional subtract is enough for the wrap.
  logic [2:0] sum  [NREQ];
  logic [1:0] cand [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign sum[gi]  = {1'b0, ptr_i} + 3'(gi);
    assign cand[gi] = (sum[gi] >= 3'(NREQ)) ? 2'(sum[gi] - 3'(NREQ)) : sum[gi][1:0];
  end

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (en_i && !any_o && req_i[cand[k]]) begin
        any_o          = 1'b1;
        idx_o          = cand[k];
        grant_o[cand[k]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_mrdma_rd_req_arb.sv
// Round-robin arbiter / sequencer for the SDP MRDMA ingress read-request path.
// Shares one read-request channel among NREQ requesters and issues exactly
// reg2dp_req_total requests per layer, then pulses arb_op_done.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   op_load, reg2dp_req_total        : layer start pulse and request count
//   req_valid / req_pd / req_ready   : per-requester handshake (payload i at [i*PW +: PW])
//   arb_rd_req_valid/_pd/_ready      : registered output request stage
//   arb_busy, arb_op_done            : in RUN / one-cycle end-of-layer pulse
//   arb_last_id                      : index of the most recent grant
module nv_nvdla_sdp_mrdma_rd_req_arb
  import nv_nvdla_sdp_mrdma_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = SDP_MRDMA_RD_REQ_PW,
  parameter int CW   = 14
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 op_load,
  input  logic [CW-1:0]        reg2dp_req_total,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*PW-1:0]   req_pd,
  output logic [NREQ-1:0]      req_ready,
  output logic                 arb_rd_req_valid,
  output logic [PW-1:0]        arb_rd_req_pd,
  input  logic                 arb_rd_req_ready,
  output logic                 arb_busy,
  output logic                 arb_op_done,
  output logic [1:0]           arb_last_id
);

  arb_state_e    state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] issued_cnt_q, issued_cnt_d;
  logic [CW-1:0] total_q, total_d;
  logic          valid_q, valid_d;
  logic [1:0]    last_id_q, last_id_d;
  logic [PW-1:0] pd_q, pd_d;

  logic [PW-1:0] pd_arr [NREQ];
  logic [PW-1:0] pd_sel;
  logic [NREQ-1:0] grant;
  logic [1:0]    gnt_idx;
  logic          gnt_any;
  logic          take;
  logic          pick_en;
  logic          xfer;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign pd_arr[gi] = req_pd[gi*PW +: PW];
  end

  // Output slot can accept a new request when empty or draining this cycle.
  assign take    = !valid_q || arb_rd_req_ready;
  assign pick_en = (state_q == RUN) && take && (issued_cnt_q < total_q);

  nv_nvdla_sdp_mrdma_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (pick_en),
    .grant_o (grant),
    .idx_o   (gnt_idx),
    .any_o   (gnt_any)
  );

  assign xfer = gnt_any && |(req_valid & grant);

  // One-hot AND-OR payload mux.
  always_comb begin
    pd_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) pd_sel = pd_sel | pd_arr[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    issued_cnt_d = issued_cnt_q;
    total_d      = total_q;
    valid_d      = valid_q;
    last_id_d    = last_id_q;
    pd_d         = pd_q;

    if (take) valid_d = xfer;
    if (xfer) begin
      pd_d         = pd_sel;
      issued_cnt_d = issued_cnt_q + CW'(1);
      rr_ptr_d     = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;
      last_id_d    = gnt_idx;
    end

    unique case (state_q)
      IDLE: begin
        if (op_load) begin
          state_d      = RUN;
          total_d      = reg2dp_req_total;
          issued_cnt_d = '0;
        end
      end
      RUN: begin
        // Leave only once the last issued request has left (or is leaving) the slot.
        if ((issued_cnt_q == total_q) && take) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= REQ_MUL;
      issued_cnt_q <= '0;
      total_q      <= '0;
      valid_q      <= 1'b0;
      last_id_q    <= REQ_MUL;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      issued_cnt_q <= issued_cnt_d;
      total_q      <= total_d;
      valid_q      <= valid_d;
      last_id_q    <= last_id_d;
    end
  end

  // Payload register is deliberately not reset; it is qualified by valid_q.
  always_ff @(posedge nvdla_core_clk) begin
    pd_q <= pd_d;
  end

  assign req_ready        = grant;
  assign arb_rd_req_valid = valid_q;
  assign arb_rd_req_pd    = pd_q;
  assign arb_busy         = (state_q == RUN);
  assign arb_op_done      = (state_q == DONE);
  assign arb_last_id      = last_id_q;

endmodule

// File: doc/nv_nvdla_sdp_mrdma_rd_req_arb.md
Name: nv_nvdla_sdp_mrdma_rd_req_arb

Overview:
- Round-robin arbiter and sequencer for the SDP MRDMA ingress read-request path.
- Shares one 79-bit read-request channel among NREQ surface requesters (e.g. MUL/ALU/batch-norm ops).
- Issues exactly a programmed number of requests per layer, then pulses done.
- Output is a registered valid/ready stage that feeds the downstream read-request pipe.

Parameters:
- NREQ, 3, number of requesters (2..4).
- PW, 79, request payload width.
- CW, 14, width of the request-count registers.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- op_load  in  1  single-cycle layer-start pulse
- reg2dp_req_total  in  CW  requests to issue this layer; sampled on op_load
- req_valid  in  NREQ  per-requester request valid
- req_pd  in  NREQ*PW  packed payloads; requester i occupies bits [i*PW +: PW]
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- arb_rd_req_valid  out  1  output request valid
- arb_rd_req_pd  out  PW  output payload
- arb_rd_req_ready  in  1  downstream accept
- arb_busy  out  1  high while in RUN
- arb_op_done  out  1  single-cycle end-of-layer pulse
- arb_last_id  out  2  requester index of the most recent grant

Behaviour:
- Reset: state=IDLE; rr_ptr=0; issued_cnt=0; total_q=0.
- Reset values of outputs:
  - arb_rd_req_valid=0, arb_busy=0, arb_op_done=0, arb_last_id=0, req_ready=0.
  - arb_rd_req_pd holds its value, not reset.
- States:
  - IDLE: op_load -> RUN; total_q<=reg2dp_req_total; issued_cnt<=0.
  - RUN: grant while issued_cnt<total_q. When issued_cnt==total_q and the output register is empty (or being accepted this cycle) -> DONE.
  - DONE: arb_op_done=1 for exactly one cycle -> IDLE.
- op_load in RUN or DONE is ignored.
- total=0: IDLE -> RUN -> DONE -> IDLE, with no grants and arb_op_done asserted 2 cycles after op_load.
- Output stage:
  - take = !arb_rd_req_valid || arb_rd_req_ready.
  - Arbitrate only when state==RUN && take && issued_cnt<total_q.
- Grant selection:
  - First requester with req_valid=1, searching circularly from rr_ptr.
  - req_ready[g]=1 combinationally in that same cycle; every other bit of req_ready is 0.
  - The request is transferred when req_valid[g] && req_ready[g].
- On transfer:
  - arb_rd_req_pd<=req_pd[g]; arb_rd_req_valid<=1 on the next edge (latency 1).
  - issued_cnt+=1; rr_ptr<=(g+1) mod NREQ; arb_last_id<=g.
- No transfer while take=1: arb_rd_req_valid<=0.
- take=0: valid and payload hold stable (valid/ready rules: no drop, no change while stalled).
- Throughput: a transfer and a downstream accept in the same cycle sustain 1 request/cycle.
- No req_valid while granting is allowed: rr_ptr unchanged.
- Count limit: once issued_cnt==total_q, req_ready=0 for all requesters, even with requests pending.
- issued_cnt never exceeds total_q and does not wrap.
- Requesters must hold req_valid/req_pd until accepted; the arbiter makes no fairness promise beyond round-robin.
- Reset mid-operation: immediate return to the reset values, and any in-flight output request is discarded.

Decomposition:
- Shared package nv_nvdla_sdp_mrdma_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - SDP_MRDMA_RD_REQ_PW=79;
  - the requester-index constants (MUL=0, ALU=1, BN=2).
- One sub-module: nv_nvdla_sdp_mrdma_rr_pick.
  - Combinational, parameterised NREQ.
  - Inputs: request vector, pointer, enable. Outputs: one-hot grant, index, any.
- The state machine, counter and output register live in the top module.

Test Plan:
- Basic sequencing: op_load with total=4, req 0 only valid, ready=1 -> 4 transfers on consecutive cycles; arb_rd_req_valid first seen 1 cycle after the first grant; arb_op_done pulses once; arb_busy falls.
- Fairness: all 3 requesters valid, total=6, ready=1 -> grant order 0,1,2,0,1,2; arb_last_id sequence matches.
- Backpressure: arb_rd_req_ready=0 for 5 cycles mid-stream -> arb_rd_req_pd stable, req_ready=0 throughout, no lost or duplicated payload; 8 distinct payloads in, 8 out, in order.
- Zero total: total=0 -> no req_ready ever; arb_op_done exactly 2 cycles after op_load.
- Limit and ignore: total=2 with requests still pending -> exactly 2 grants; a second op_load during RUN is ignored; a subsequent op_load in IDLE with total=3 issues 3 more.
- Reset: assert nvdla_core_rstn=0 with an output pending -> arb_rd_req_valid=0 and arb_busy=0 immediately (asynchronous); after release, rr_ptr=0, so the first grant goes to requester 0.
